// File: rtl/rp_sd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rp_sd_arbiter_if
// Purpose  : Bundles the drive-side request/acknowledge bus and the
//            SD-controller command/completion bus of the RP SD arbiter.
// Signals  : rpSDREQ[8]      per-drive service request (level)
//            rpSDOP[8][3]    per-drive operation code
//            rpSDLSA[8][21]  per-drive linear sector address
//            rpSDACK[8]      one-hot completion acknowledge
//            sdSTART         launch pulse to SD controller
//            sdOP/sdLSA      latched op / sector of granted drive
//            sdSCAN          granted drive number
//            sdDONE          completion pulse from SD controller
//            sdABORT         abandon-operation pulse to SD controller
// Modports : master -- the arbiter; slave -- drives plus SD controller
// Revision : 1.0  initial release
// ============================================================================
interface rp_sd_arbiter_if;
  logic [7:0]        rpSDREQ;
  logic [7:0][2:0]   rpSDOP;
  logic [7:0][20:0]  rpSDLSA;
  logic [7:0]        rpSDACK;
  logic              sdSTART;
  logic [2:0]        sdOP;
  logic [20:0]       sdLSA;
  logic [2:0]        sdSCAN;
  logic              sdDONE;
  logic              sdABORT;

  modport master (
    input  rpSDREQ, rpSDOP, rpSDLSA, sdDONE,
    output rpSDACK, sdSTART, sdOP, sdLSA, sdSCAN, sdABORT
  );

  modport slave (
    output rpSDREQ, rpSDOP, rpSDLSA, sdDONE,
    input  rpSDACK, sdSTART, sdOP, sdLSA, sdSCAN, sdABORT
  );
endinterface
`default_nettype wire

// File: rtl/rp_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rp_sd_arbiter
// Purpose  : Round-robin arbiter granting one of eight RP drives access to a
//            shared SD controller. A grant latches the drive's op/sector,
//            issues a one-cycle sdSTART, waits for sdDONE and returns a
//            one-cycle one-hot rpSDACK to the granted drive.
// Ports    : clk      system clock, rising edge
//            rst_n    asynchronous active-low reset
//            clr      synchronous controller clear (massbus INIT)
//            bus      rp_sd_arbiter_if.master (request/ack + SD command bus)
//            arbBUSY  high in every state except IDLE
//            arbTMO   sticky watchdog-timeout flag
// Params   : TMO_CYCLES  watchdog limit in BUSY clk cycles
// Options  : RP_SDARB_WATCHDOG_EN  when defined, builds a 24-bit BUSY
//            watchdog that aborts a hung operation and releases the drive.
//            When undefined, BUSY waits indefinitely and arbTMO is 0.
// Revision : 1.0  initial release
// ============================================================================
module rp_sd_arbiter #(
  parameter logic [23:0] TMO_CYCLES = 24'd10_000_000
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clr,
  rp_sd_arbiter_if.master   bus,
  output logic              arbBUSY,
  output logic              arbTMO
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    ACK   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t       state;
  logic [2:0]   ptr;          // last drive acknowledged; search begins at ptr+1

  // Registered outputs
  logic [7:0]   ack_q;
  logic         start_q;
  logic         abort_q;
  logic [2:0]   op_q;
  logic [20:0]  lsa_q;
  logic [2:0]   scan_q;
  logic         busy_q;

  // Round-robin pick
  logic         grant_vld;
  logic [2:0]   grant_idx;

  // Watchdog expiry this cycle (constant 0 when the watchdog is not built)
  logic         wd_expire;

  // --------------------------------------------------------------------------
  // Round-robin search. Offsets are walked from 8 down to 1 so the last hit,
  // i.e. the smallest offset from ptr, wins. Offset 8 wraps to ptr itself,
  // giving the most recently served drive the lowest priority.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [2:0] idx;
    grant_vld = 1'b0;
    grant_idx = 3'd0;
    idx       = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr + k[2:0];
      if (bus.rpSDREQ[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional BUSY watchdog
  // --------------------------------------------------------------------------
`ifdef RP_SDARB_WATCHDOG_EN
  logic [23:0] wd_cnt;
  logic        tmo_q;

  // The counter is cleared as BUSY is entered and counts BUSY cycles; expiry
  // fires on the edge at which the count would reach TMO_CYCLES.
  assign wd_expire = ((wd_cnt + 24'd1) == TMO_CYCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= 24'd0;
      tmo_q  <= 1'b0;
    end else begin
      if (state == START) begin
        wd_cnt <= 24'd0;
      end else if (state == BUSY) begin
        wd_cnt <= wd_cnt + 24'd1;
      end

      // Same priority as the FSM: clr, then sdDONE, then expiry.
      if (clr) begin
        tmo_q <= 1'b0;
      end else if ((state == BUSY) && !bus.sdDONE && wd_expire) begin
        tmo_q <= 1'b1;
      end
    end
  end

  assign arbTMO = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYCLES;
  assign wd_expire  = 1'b0;
  assign arbTMO     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Arbiter FSM. All outputs are registered and change on the edge that
  // enters the state they belong to, except sdSTART which is raised on the
  // START->BUSY edge so the SD controller sees it together with a stable
  // sdOP/sdLSA/sdSCAN that were latched one edge earlier.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd7;
      ack_q   <= 8'd0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      op_q    <= 3'd0;
      lsa_q   <= 21'd0;
      scan_q  <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      start_q <= 1'b0;
      ack_q   <= 8'd0;
      abort_q <= 1'b0;

      if (clr) begin
        // Only an operation actually handed to the SD controller needs to
        // be abandoned; ptr is deliberately left alone.
        if ((state == START) || (state == BUSY)) begin
          abort_q <= 1'b1;
        end
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (grant_vld) begin
              scan_q <= grant_idx;
              op_q   <= bus.rpSDOP[grant_idx];
              lsa_q  <= bus.rpSDLSA[grant_idx];
              state  <= START;
              busy_q <= 1'b1;
            end
          end

          START: begin
            start_q <= 1'b1;
            state   <= BUSY;
          end

          BUSY: begin
            // The request level is not examined here: a drive dropping its
            // request mid-operation still receives its acknowledge.
            if (bus.sdDONE) begin
              ack_q <= 8'd1 << scan_q;
              state <= ACK;
            end else if (wd_expire) begin
              abort_q <= 1'b1;
              ack_q   <= 8'd1 << scan_q;
              state   <= ACK;
            end
          end

          ACK: begin
            ptr   <= scan_q;
            state <= HOLD;
          end

          HOLD: begin
            // Gives the acknowledged drive a cycle to drop its request
            // before the next search.
            state  <= IDLE;
            busy_q <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rpSDACK = ack_q;
  assign bus.sdSTART = start_q;
  assign bus.sdABORT = abort_q;
  assign bus.sdOP    = op_q;
  assign bus.sdLSA   = lsa_q;
  assign bus.sdSCAN  = scan_q;
  assign arbBUSY     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rp_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rp_sd_arbiter
// Purpose  : Self-checking bench for rp_sd_arbiter. A driver plays the drives
//            and the SD controller and pushes expected sdSTART / rpSDACK /
//            sdABORT events into queues; a negedge monitor pops and compares
//            whenever the DUT presents one of those events.
// Options  : RP_SDARB_WATCHDOG_EN  also exercises the watchdog (TMO 100).
// Revision : 1.0  initial release
// ============================================================================
module tb_rp_sd_arbiter;

`ifdef RP_SDARB_WATCHDOG_EN
  localparam logic [23:0] TB_TMO = 24'd100;
`else
  localparam logic [23:0] TB_TMO = 24'd10_000_000;
`endif

  localparam int M_NORMAL    = 0;
  localparam int M_CLR_START = 1;
  localparam int M_CLR_BUSY  = 2;
  localparam int M_CLR_DONE  = 3;
  localparam int M_TMO       = 4;
  localparam int M_RESET     = 5;

  logic clk;
  logic rst_n;
  logic clr;
  logic arbBUSY;
  logic arbTMO;

  rp_sd_arbiter_if bus ();

  rp_sd_arbiter #(.TMO_CYCLES(TB_TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .bus     (bus),
    .arbBUSY (arbBUSY),
    .arbTMO  (arbTMO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int scan; int op; int lsa; int cyc; } start_t;
  typedef struct { logic [7:0] val; int cyc; } ack_t;

  start_t q_start[$];
  ack_t   q_ack[$];
  int     q_abort[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: the last acknowledged drive.
  int         ptr_m;
  logic [2:0] op_a  [8];
  logic [20:0] lsa_a[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // First requester strictly after p, wrapping modulo 8.
  function automatic int pick(input logic [7:0] m, input int p);
    for (int k = 1; k <= 8; k++) begin
      if (m[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [63:0] outs();
    return {25'd0, bus.rpSDACK, bus.sdSTART, bus.sdOP, bus.sdLSA,
            bus.sdSCAN, bus.sdABORT, arbBUSY, arbTMO};
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sdSTART) begin
        if (q_start.size() == 0) chk("start_unexpected", 64'(bus.sdSTART), 64'd0);
        else begin
          start_t s;
          s = q_start.pop_front();
          chk("start_scan", 64'(bus.sdSCAN), 64'(s.scan));
          chk("start_op",   64'(bus.sdOP),   64'(s.op));
          chk("start_lsa",  64'(bus.sdLSA),  64'(s.lsa));
          chk("start_cyc",  64'(cyc),        64'(s.cyc));
        end
      end
      if (bus.rpSDACK != 8'd0) begin
        chk("ack_onehot", 64'($countones(bus.rpSDACK)), 64'd1);
        if (q_ack.size() == 0) chk("ack_unexpected", 64'(bus.rpSDACK), 64'd0);
        else begin
          ack_t a;
          a = q_ack.pop_front();
          chk("ack_val", 64'(bus.rpSDACK), 64'(a.val));
          chk("ack_cyc", 64'(cyc),         64'(a.cyc));
        end
      end
      if (bus.sdABORT) begin
        if (q_abort.size() == 0) chk("abort_unexpected", 64'(bus.sdABORT), 64'd0);
        else chk("abort_cyc", 64'(cyc), 64'(q_abort.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // Called at posedge+1 with the DUT idle; returns at posedge+1.
  task automatic transact(input logic [7:0] mask, input int mode, input int dly,
                          input bit drop, input bit spur, input bit hold_clr,
                          input bit rnd);
    int w, n, s;
    start_t es;
    ack_t   ea;
    if (rnd) begin
      for (int i = 0; i < 8; i++) begin
        op_a[i]  = 3'($urandom_range(0, 7));
        lsa_a[i] = 21'($urandom);
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus.rpSDOP[i]  = op_a[i];
      bus.rpSDLSA[i] = lsa_a[i];
    end
    bus.rpSDREQ = mask;
    w = pick(mask, ptr_m);
    n = cyc;
    if (mode != M_CLR_START) begin
      es.scan = w; es.op = int'(op_a[w]); es.lsa = int'(lsa_a[w]); es.cyc = n + 2;
      q_start.push_back(es);
    end
    @(posedge clk); #1;                         // START
    if (mode == M_CLR_START) begin
      clr = 1'b1;
      q_abort.push_back(cyc + 1);
      @(posedge clk); #1;
      clr = 1'b0;
      bus.rpSDREQ = 8'd0;
      chk("busy_after_clr", 64'(arbBUSY), 64'd0);
      return;
    end
    bus.sdDONE = spur;                          // must be ignored in START
    @(posedge clk); #1;                         // first BUSY cycle, sdSTART high
    bus.sdDONE = 1'b0;
    s = cyc;
    chk("busy_in_service", 64'(arbBUSY), 64'd1);
    if (drop) bus.rpSDREQ[w] = 1'b0;
    if (mode == M_TMO) begin
      q_abort.push_back(s + int'(TB_TMO));
      ea.val = 8'd1 << w; ea.cyc = s + int'(TB_TMO);
      q_ack.push_back(ea);
      repeat (int'(TB_TMO)) @(posedge clk);
      #1;
      chk("tmo_set", 64'(arbTMO), 64'd1);
      bus.rpSDREQ[w] = 1'b0;
      ptr_m = w;
      repeat (2) @(posedge clk);
      #1;
      chk("tmo_sticky", 64'(arbTMO), 64'd1);
      bus.rpSDREQ = 8'd0;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("tmo_cleared", 64'(arbTMO), 64'd0);
      return;
    end
    repeat (dly) begin @(posedge clk); #1; end
    case (mode)
      M_RESET: begin
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_busy_outputs", outs(), 64'd0);
        bus.rpSDREQ = 8'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ptr_m = 7;
      end
      M_CLR_BUSY, M_CLR_DONE: begin
        clr = 1'b1;
        bus.sdDONE = (mode == M_CLR_DONE);
        q_abort.push_back(cyc + 1);
        @(posedge clk); #1;
        clr = 1'b0;
        bus.sdDONE = 1'b0;
        bus.rpSDREQ = 8'd0;
        chk("busy_after_clr", 64'(arbBUSY), 64'd0);
      end
      default: begin
        bus.sdDONE = 1'b1;
        ea.val = 8'd1 << w; ea.cyc = cyc + 1;
        q_ack.push_back(ea);
        @(posedge clk); #1;                     // ACK
        bus.sdDONE = 1'b0;
        bus.rpSDREQ[w] = 1'b0;
        ptr_m = w;
        @(posedge clk); #1;                     // HOLD
        clr = hold_clr;
        @(posedge clk); #1;                     // IDLE
        clr = 1'b0;
        chk("idle_not_busy", 64'(arbBUSY), 64'd0);
      end
    endcase
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst_n = 1'b0; clr = 1'b0;
    bus.sdDONE = 1'b0; bus.rpSDREQ = 8'd0;
    for (int i = 0; i < 8; i++) begin
      op_a[i] = 3'd0; lsa_a[i] = 21'd0;
      bus.rpSDOP[i] = 3'd0; bus.rpSDLSA[i] = 21'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    ptr_m = 7;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'(arbBUSY), 64'd0);

    // Directed two-drive case: drive 0 first, then drive 7.
    op_a[0] = 3'd1; lsa_a[0] = 21'h000010;
    op_a[7] = 3'd2; lsa_a[7] = 21'h1FFFFF;
    transact(8'h81, M_NORMAL, 2, 0, 0, 0, 0);
    transact(8'h80, M_NORMAL, 1, 0, 0, 0, 0);

    // Round robin from ptr = 3 with everyone requesting.
    transact(8'h08, M_NORMAL, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      transact(8'hFF, M_NORMAL, $urandom_range(0, 3), 0, 0, 0, 1);

    // clr during BUSY on drive 2 with ptr = 2; next search starts at 3.
    transact(8'h04, M_NORMAL, 1, 0, 0, 0, 1);
    transact(8'h04, M_CLR_BUSY, 1, 0, 0, 0, 1);
    transact(8'h0C, M_NORMAL, 0, 0, 0, 0, 1);

    // Drive 5 drops its request mid-service and is still acknowledged.
    transact(8'h20, M_NORMAL, 3, 1, 0, 0, 1);
    transact(8'h10, M_CLR_START, 0, 0, 0, 0, 1);
    transact(8'h41, M_CLR_DONE, 2, 0, 0, 0, 1);

    // Randomized traffic with drops, stray sdDONE, and clr in HOLD / IDLE.
    for (int i = 0; i < 24; i++) begin
      transact(8'($urandom_range(1, 255)), M_NORMAL, $urandom_range(0, 4),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 3) == 0) begin
        bus.rpSDREQ = 8'd0;
        bus.sdDONE  = 1'b1;
        clr         = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        bus.sdDONE  = 1'b0;
        clr         = 1'b0;
      end
    end

`ifdef RP_SDARB_WATCHDOG_EN
    transact(8'h02, M_TMO, 0, 0, 0, 0, 1);
`endif

    // Asynchronous reset mid-operation, then drive 0 wins again.
    transact(8'h40, M_RESET, 2, 0, 0, 0, 1);
    transact(8'hFF, M_NORMAL, 1, 0, 0, 0, 1);
    chk("tmo_default_zero", 64'(arbTMO), 64'd0);

    bus.rpSDREQ = 8'd0;
    repeat (5) @(posedge clk);
    #1;
    chk("start_queue_drained", 64'(q_start.size()), 64'd0);
    chk("ack_queue_drained",   64'(q_ack.size()),   64'd0);
    chk("abort_queue_drained", 64'(q_abort.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rp_sd_arbiter.md
RP_SD_ARBITER -- requirements
Module: rp_sd_arbiter

Interface
REQ-001 Parameter: TMO_CYCLES, default 24'd10_000_000, watchdog limit in clk cycles.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 clr  input  1  synchronous controller clear (massbus INIT).
REQ-005 rpSDREQ  input  8  per-drive SD service request, level, bit i = drive i.
REQ-006 rpSDOP  input  3x8  per-drive SD operation code.
REQ-007 rpSDLSA  input  21x8  per-drive linear sector address.
REQ-008 rpSDACK  output  8  one-hot, one-cycle completion acknowledge.
REQ-009 sdSTART  output  1  one-cycle pulse, launches SD operation.
REQ-010 sdOP  output  3  latched operation of granted drive.
REQ-011 sdLSA  output  21  latched sector address of granted drive.
REQ-012 sdSCAN  output  3  granted drive number.
REQ-013 sdDONE  input  1  one-cycle pulse from SD controller, operation complete.
REQ-014 sdABORT  output  1  one-cycle pulse, commands SD controller to abandon operation.
REQ-015 arbBUSY  output  1  high in every state except IDLE.
REQ-016 arbTMO  output  1  sticky watchdog-timeout flag (0 when RP_SDARB_WATCHDOG_EN is undefined).

Function
REQ-017 The FSM SHALL have states IDLE, START, BUSY, ACK, HOLD.
REQ-018 IDLE: when any rpSDREQ bit is set, grant the first set bit searching upward from ptr+1 modulo 8; latch unit into sdSCAN and the unit's op/LSA into sdOP/sdLSA in the same edge; go to START.
REQ-019 START: assert sdSTART for exactly one cycle; go to BUSY.
REQ-020 BUSY: hold sdOP, sdLSA and sdSCAN stable; on sdDONE go to ACK.
REQ-021 ACK: assert rpSDACK[sdSCAN] for exactly one cycle; set ptr to sdSCAN; go to HOLD.
REQ-022 HOLD: one idle cycle so the acknowledged drive can drop its request; go to IDLE.
REQ-023 Latency: request-to-sdSTART is 2 cycles; sdDONE-to-rpSDACK is 1 cycle; minimum grant-to-grant spacing is 4 cycles plus the SD service time.
REQ-024 Round-robin: with all 8 requesting continuously, grants follow ptr+1, ptr+2, ..., wrapping from 7 to 0; no drive is granted twice before every other requester has been granted once.
REQ-025 Deassertion of rpSDREQ[sdSCAN] during START or BUSY SHALL NOT cancel the operation; ACK is still issued.
REQ-026 sdDONE outside BUSY SHALL be ignored.
REQ-027 clr in any state SHALL return the FSM to IDLE on the next edge and leave ptr unchanged; no rpSDACK is issued.
REQ-028 When clr is sampled in START or BUSY, sdABORT SHALL pulse for one cycle; clr sampled in IDLE, ACK or HOLD SHALL NOT pulse sdABORT.
REQ-029 clr SHALL take priority over a coincident sdDONE.
REQ-030 rpSDACK SHALL never have more than one bit set.

Reset
REQ-031 rst_n low SHALL asynchronously set the state to IDLE and ptr to 7, so drive 0 is granted first.
REQ-032 rst_n low SHALL clear rpSDACK, sdSTART and sdABORT to 0, sdOP to 0, sdLSA to 0, sdSCAN to 0, arbBUSY to 0, arbTMO to 0, and the watchdog counter to 0.
REQ-033 Reset asserted mid-operation SHALL NOT produce sdABORT or rpSDACK.

Configuration
REQ-034 Macro RP_SDARB_WATCHDOG_EN defined: a 24-bit counter clears on entry to BUSY and increments each BUSY cycle.
REQ-035 When that counter reaches TMO_CYCLES, the block SHALL pulse sdABORT, set arbTMO, and go to ACK so the requester is released.
REQ-036 arbTMO SHALL clear only on clr or reset.
REQ-037 Macro undefined: no counter is built, BUSY waits indefinitely for sdDONE or clr, and arbTMO is tied to 0.

Verification
REQ-038 After reset, raise rpSDREQ=8'h81 (drive 0 op 3'd1 LSA 21'h000010, drive 7 op 3'd2 LSA 21'h1FFFFF) -> sdSCAN=0, sdOP=1, sdLSA=10h, sdSTART 2 cycles later; after sdDONE, rpSDACK=8'h01; next grant sdSCAN=7, sdLSA=1FFFFFh.
REQ-039 Hold rpSDREQ=8'hFF for 16 completions with ptr=3 -> grant order 4,5,6,7,0,1,2,3,4,...; no repeats within any 8 grants.
REQ-040 Pulse clr during BUSY on drive 2 -> exactly one sdABORT pulse, no rpSDACK, arbBUSY=0 next cycle; the next grant starts at drive 3.
REQ-041 Drive 5 drops rpSDREQ during BUSY -> rpSDACK=8'h20 still issued one cycle after sdDONE.
REQ-042 With RP_SDARB_WATCHDOG_EN defined and TMO_CYCLES=100, withhold sdDONE -> sdABORT and arbTMO asserted 100 BUSY cycles after START, followed by rpSDACK for that drive; arbTMO stays 1 until clr.
REQ-043 Assert rst_n=0 asynchronously mid-BUSY -> all outputs 0 immediately, no sdABORT; after release, drive 0 is granted first.
